// File: rtl/mips_exec_unit.sv
// mips_exec_unit
//   Execute stage of the multicycle MIPS core. Decodes ALUOp/funct into a
//   4-bit ALU operation, computes the 32-bit ALU result and zero flag, and
//   forms the branch target (pc + offset). The combinational result feeds the
//   control/PC muxes directly; alu_out_q keeps a copy across multicycle states.
// Ports
//   clk, reset        clock, asynchronous active-low reset (clears alu_out_q)
//   alu_op[1:0]       00 add, 01 sub, 10 R-type (use func_code), 11 slt
//   func_code[5:0]    instr[5:0]
//   shamt[4:0]        instr[10:6], used only by sll/srl/sra
//   a, b [31:0]       operands (rs, rt/immediate)
//   pc, offset [31:0] current PC and pre-shifted branch offset
//   aluout_we         capture enable for alu_out_q
//   alu_ctrl[3:0]     decoded operation
//   result[31:0]      combinational ALU result
//   zero              result == 0
//   branch_target     pc + offset (wraps)
//   alu_out_q[31:0]   registered result
module mips_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  func_code,
    input  logic [4:0]  shamt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] pc,
    input  logic [31:0] offset,
    input  logic        aluout_we,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic [31:0] branch_target,
    output logic [31:0] alu_out_q
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SRAV = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SLLV = 4'b1101;
    localparam logic [3:0] OP_SRLV = 4'b1110;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    logic [31:0] alu_out_d;
    logic [4:0]  vsh;

    // ALU-control decode
    always_comb begin
        alu_ctrl = OP_NOP;
        unique case (alu_op)
            2'b00: alu_ctrl = OP_ADD;
            2'b01: alu_ctrl = OP_SUB;
            2'b11: alu_ctrl = OP_SLT;
            default: begin
                case (func_code)
                    6'b100000, 6'b100001: alu_ctrl = OP_ADD;
                    6'b100010, 6'b100011: alu_ctrl = OP_SUB;
                    6'b100100: alu_ctrl = OP_AND;
                    6'b100101: alu_ctrl = OP_OR;
                    6'b100110: alu_ctrl = OP_XOR;
                    6'b100111: alu_ctrl = OP_NOR;
                    6'b101010: alu_ctrl = OP_SLT;
                    6'b101011: alu_ctrl = OP_SLTU;
                    6'b000000: alu_ctrl = OP_SLL;
                    6'b000010: alu_ctrl = OP_SRL;
                    6'b000011: alu_ctrl = OP_SRA;
                    6'b000100: alu_ctrl = OP_SLLV;
                    6'b000110: alu_ctrl = OP_SRLV;
                    6'b000111: alu_ctrl = OP_SRAV;
                    default:   alu_ctrl = OP_NOP;
                endcase
            end
        endcase
    end

    // Variable shifts take their amount from rs[4:0]
    assign vsh = a[4:0];

    always_comb begin
        result = 32'h0;
        case (alu_ctrl)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_XOR:  result = a ^ b;
            OP_SUB:  result = a - b;
            OP_NOR:  result = ~(a | b);
            OP_SLT:  result = {31'h0, $signed(a) < $signed(b)};
            OP_SLTU: result = {31'h0, a < b};
            OP_SLL:  result = b << shamt;
            OP_SRL:  result = b >> shamt;
            OP_SRA:  result = $unsigned($signed(b) >>> shamt);
            OP_SLLV: result = b << vsh;
            OP_SRLV: result = b >> vsh;
            OP_SRAV: result = $unsigned($signed(b) >>> vsh);
            default: result = 32'h0;   // NOP and unused encodings
        endcase
    end

    assign zero          = (result == 32'h0);
    assign branch_target = pc + offset;

    always_comb begin
        alu_out_d = alu_out_q;
        if (aluout_we) alu_out_d = result;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) alu_out_q <= 32'h0;
        else        alu_out_q <= alu_out_d;
    end

endmodule

// File: tb/tb_mips_exec_unit.sv
// tb_mips_exec_unit
//   Directed vectors with hand-computed expectations. The driver applies a
//   vector just after each rising edge and queues its expected outputs; the
//   monitor pops and compares on the following falling edge.
module tb_mips_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [5:0]  func_code = 6'h0;
    logic [4:0]  shamt = 5'h0;
    logic [31:0] a = 32'h0, b = 32'h0, pc = 32'h0, offset = 32'h0;
    logic        aluout_we = 1'b0;
    logic [3:0]  alu_ctrl;
    logic [31:0] result, branch_target, alu_out_q;
    logic        zero;

    always #5 clk = ~clk;

    mips_exec_unit dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .func_code(func_code),
        .shamt(shamt), .a(a), .b(b), .pc(pc), .offset(offset),
        .aluout_we(aluout_we), .alu_ctrl(alu_ctrl), .result(result),
        .zero(zero), .branch_target(branch_target), .alu_out_q(alu_out_q)
    );

    typedef struct {
        int          id;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        z;
        logic [31:0] bt;
        logic [31:0] aq;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] model_q = 32'h0;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    // Monitor: the DUT output is combinational, so it is "presented" every
    // cycle; compare whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk(e.id, "alu_ctrl",      {28'h0, alu_ctrl}, {28'h0, e.ctrl});
                chk(e.id, "result",        result,            e.res);
                chk(e.id, "zero",          {31'h0, zero},     {31'h0, e.z});
                chk(e.id, "branch_target", branch_target,     e.bt);
                chk(e.id, "alu_out_q",     alu_out_q,         e.aq);
            end
        end
    end

    task automatic vec(input int id, input logic rst, input logic we, input logic [1:0] op,
                       input logic [5:0] fn, input logic [4:0] sh, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] vpc, input logic [31:0] voff,
                       input logic [3:0] ectrl, input logic [31:0] eres, input logic [31:0] ebt);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst; aluout_we = we; alu_op = op; func_code = fn; shamt = sh;
        a = va; b = vb; pc = vpc; offset = voff;
        if (!rst) model_q = 32'h0;
        e.id = id; e.ctrl = ectrl; e.res = eres; e.z = (eres == 32'h0);
        e.bt = ebt; e.aq = model_q;
        sb.push_back(e);
        // Capture happens at the next rising edge, seen by the next vector
        if (rst && we) model_q = eres;
    endtask

    initial begin
        int wait_cyc;
        //   id rst we  op     funct      sh  a             b             pc            off           ctrl   result        bt
        vec( 1, 0, 1, 2'b00, 6'h00,     0, 32'hFFFF_FFFF, 32'h1,        32'hBFC0_0000, 32'h10,      4'h2, 32'h0,        32'hBFC0_0010);
        vec( 2, 1, 1, 2'b00, 6'h00,     0, 32'h2,         32'h3,        32'h100,       32'h4,       4'h2, 32'h5,        32'h104);
        vec( 3, 1, 0, 2'b10, 6'b101010, 0, 32'hFFFF_FFFE, 32'h1,        32'h0,         32'h0,       4'h7, 32'h1,        32'h0);
        vec( 4, 1, 0, 2'b10, 6'b101011, 0, 32'hFFFF_FFFE, 32'h1,        32'h0,         32'h0,       4'hB, 32'h0,        32'h0);
        vec( 5, 1, 0, 2'b10, 6'b000011, 4, 32'h0,         32'h8000_0000,32'h0,         32'h0,       4'hA, 32'hF800_0000,32'h0);
        vec( 6, 1, 0, 2'b10, 6'b000010, 4, 32'h0,         32'h8000_0000,32'h0,         32'h0,       4'h9, 32'h0800_0000,32'h0);
        vec( 7, 1, 0, 2'b01, 6'b111111, 0, 32'h1234,      32'h1234,     32'hBFC0_0000, 32'h10,      4'h6, 32'h0,        32'hBFC0_0010);
        vec( 8, 1, 0, 2'b10, 6'b111111, 3, 32'h5,         32'h7,        32'h0,         32'h0,       4'hF, 32'h0,        32'h0);
        vec( 9, 1, 0, 2'b10, 6'b100111, 0, 32'h0,         32'h0,        32'h0,         32'h0,       4'hC, 32'hFFFF_FFFF,32'h0);
        vec(10, 1, 0, 2'b11, 6'b000000, 0, 32'h3,         32'h5,        32'h0,         32'h0,       4'h7, 32'h1,        32'h0);
        vec(11, 1, 0, 2'b10, 6'b100100, 0, 32'hF0F0,      32'hFF00,     32'h0,         32'h0,       4'h0, 32'hF000,     32'h0);
        vec(12, 1, 0, 2'b10, 6'b100101, 0, 32'hF0F0,      32'hFF00,     32'h0,         32'h0,       4'h1, 32'hFFF0,     32'h0);
        vec(13, 1, 0, 2'b10, 6'b100110, 0, 32'hF0F0,      32'hFF00,     32'h0,         32'h0,       4'h3, 32'h0FF0,     32'h0);
        vec(14, 1, 0, 2'b10, 6'b000000, 8, 32'h0,         32'hFF,       32'h0,         32'h0,       4'h8, 32'hFF00,     32'h0);
        vec(15, 1, 0, 2'b10, 6'b000100, 31,32'h24,        32'h1,        32'h0,         32'h0,       4'hD, 32'h10,       32'h0);
        vec(16, 1, 0, 2'b10, 6'b000110, 31,32'h24,        32'h8000_0000,32'h0,         32'h0,       4'hE, 32'h0800_0000,32'h0);
        vec(17, 1, 0, 2'b10, 6'b000111, 31,32'h24,        32'h8000_0000,32'h0,         32'h0,       4'h5, 32'hF800_0000,32'h0);
        vec(18, 1, 1, 2'b10, 6'b100001, 0, 32'h7,         32'h1,        32'hFFFF_FFFC, 32'h8,       4'h2, 32'h8,        32'h4);
        vec(19, 1, 0, 2'b10, 6'b100011, 0, 32'h7,         32'h8,        32'h0,         32'h0,       4'h6, 32'hFFFF_FFFF,32'h0);
        vec(20, 0, 1, 2'b00, 6'h00,     0, 32'h1,         32'h1,        32'h10,        32'h20,      4'h2, 32'h2,        32'h30);
        vec(21, 1, 0, 2'b10, 6'b100010, 0, 32'h9,         32'h4,        32'h0,         32'h0,       4'h6, 32'h5,        32'h0);
        vec(22, 1, 0, 2'b00, 6'h00,     0, 32'h0,         32'h0,        32'h0,         32'h0,       4'h2, 32'h0,        32'h0);
        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
